// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates, frame markers and measured line/frame
// totals from an incoming hsync/vsync/rgb565 stream, qualified by a lock FSM.
module vga_sync_rx #(
  parameter int H_ACT0      = 144,
  parameter int H_VALID     = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACT0      = 35,
  parameter int V_VALID     = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [15:0] rgb_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_lost,
  output logic [9:0]  meas_h_total,
  output logic [9:0]  meas_v_total
);

  localparam logic [1:0] ST_UNLOCK = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

  localparam logic [9:0]  H_LO      = 10'(H_ACT0);
  localparam logic [9:0]  H_HI      = 10'(H_ACT0 + H_VALID);
  localparam logic [9:0]  V_LO      = 10'(V_ACT0);
  localparam logic [9:0]  V_HI      = 10'(V_ACT0 + V_VALID);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_GOOD = 4'(LOCK_FRAMES);

  function automatic logic [9:0] sat10(input logic [10:0] val);
    return val[10] ? 10'h3ff : val[9:0];
  endfunction

  logic        hs_s1;
  logic        vs_s1;
  logic [15:0] rgb_s1;
  logic [9:0]  h_pos;
  logic [9:0]  v_pos;
  logic        vs_pending;
  logic        first_line;
  logic        first_frame;

  logic        len_err_s1;
  logic        h_to_s1;
  logic        v_to_s1;
  logic        v_bad_s1;
  logic        v_ok_s1;
  logic        frame_s1;

  logic        hs_rise;
  logic        vs_rise;
  logic        frame_rise;
  logic [10:0] h_len;
  logic [10:0] v_len;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        err;
  logic        err_nxt;
  logic [3:0]  good;
  logic [3:0]  good_nxt;
  logic        err_evt;
  logic        window;

  // Edge detection compares the incoming sample against the one already held in stage 1.
  always_comb begin
    hs_rise    = hsync_in & ~hs_s1;
    vs_rise    = vsync_in & ~vs_s1;
    frame_rise = hs_rise & (vs_rise | vs_pending);
    h_len      = {1'b0, h_pos} + 11'd1;
    v_len      = {1'b0, v_pos} + 11'd1;
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      hs_s1        <= 1'b0;
      vs_s1        <= 1'b0;
      rgb_s1       <= 16'h0000;
      h_pos        <= 10'd0;
      v_pos        <= 10'd0;
      vs_pending   <= 1'b0;
      first_line   <= 1'b1;
      first_frame  <= 1'b1;
      meas_h_total <= 10'd0;
      meas_v_total <= 10'd0;
      len_err_s1   <= 1'b0;
      h_to_s1      <= 1'b0;
      v_to_s1      <= 1'b0;
      v_bad_s1     <= 1'b0;
      v_ok_s1      <= 1'b0;
      frame_s1     <= 1'b0;
    end else begin
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
      rgb_s1 <= rgb_in;

      h_pos <= hs_rise ? 10'd0 : sat10(h_len);
      if (hs_rise) begin
        v_pos <= frame_rise ? 10'd0 : sat10(v_len);
      end

      if (frame_rise) begin
        vs_pending <= 1'b0;
      end else if (vs_rise) begin
        vs_pending <= 1'b1;
      end

      if (hs_rise) begin
        first_line <= 1'b0;
      end
      if (frame_rise) begin
        first_frame <= 1'b0;
      end

      // Partial lines/frames seen right after reset are never measured.
      if (hs_rise && !first_line) begin
        meas_h_total <= sat10(h_len);
      end
      if (frame_rise && !first_frame) begin
        meas_v_total <= sat10(v_len);
      end

      len_err_s1 <= hs_rise & ~first_line & (h_len != H_TOTAL_W);
      h_to_s1    <= ~hs_rise & ~first_line & (h_len == H_TOTAL_W);
      v_to_s1    <= hs_rise & ~frame_rise & ~first_frame & (v_len == V_TOTAL_W);
      v_bad_s1   <= frame_rise & ~first_frame & (v_len != V_TOTAL_W);
      v_ok_s1    <= frame_rise & ~first_frame & (v_len == V_TOTAL_W);
      frame_s1   <= frame_rise;
    end
  end

  assign err_evt = len_err_s1 | h_to_s1 | v_to_s1 | v_bad_s1;

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    good_nxt  = good;
    case (state)
      ST_UNLOCK: begin
        if (frame_s1) begin
          state_nxt = ST_CHECK;
          err_nxt   = 1'b0;
          good_nxt  = 4'd0;
        end
      end
      ST_CHECK: begin
        err_nxt = err | err_evt;
        if (frame_s1) begin
          if (!err_nxt && v_ok_s1) begin
            good_nxt = good + 4'd1;
          end else begin
            good_nxt = 4'd0;
          end
          err_nxt = 1'b0;
          if (good_nxt == LOCK_GOOD) begin
            state_nxt = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (err_evt) begin
          state_nxt = ST_UNLOCK;
        end
      end
      default: state_nxt = ST_UNLOCK;
    endcase
  end

  assign window = (h_pos >= H_LO) && (h_pos < H_HI) && (v_pos >= V_LO) && (v_pos < V_HI);

  // Output stage shares the FSM update edge so a lock drop blanks pixels immediately.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state       <= ST_UNLOCK;
      err         <= 1'b0;
      good        <= 4'd0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'h3ff;
      pix_y       <= 10'h3ff;
      pix_data    <= 16'h0000;
    end else begin
      state       <= state_nxt;
      err         <= err_nxt;
      good        <= good_nxt;
      locked      <= (state_nxt == ST_LOCK);
      lock_lost   <= (state == ST_LOCK) && (state_nxt != ST_LOCK);
      frame_start <= frame_s1;
      if (window && (state_nxt == ST_LOCK)) begin
        pix_valid <= 1'b1;
        pix_x     <= h_pos - H_LO;
        pix_y     <= v_pos - V_LO;
        pix_data  <= rgb_s1;
      end else begin
        pix_valid <= 1'b0;
        pix_x     <= 10'h3ff;
        pix_y     <= 10'h3ff;
        pix_data  <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed-stream testbench for vga_sync_rx on a reduced 24x10 raster
// (same sync/porch structure as 640x480, short enough for many frames).
module tb_vga_sync_rx;

  localparam int HS  = 4;
  localparam int HA0 = 7;
  localparam int HV  = 12;
  localparam int HT  = 24;
  localparam int VS  = 2;
  localparam int VA0 = 3;
  localparam int VV  = 5;
  localparam int VT  = 10;
  localparam int LF  = 2;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        hsync_in;
  logic        vsync_in;
  logic [15:0] rgb_in;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        locked;
  logic        lock_lost;
  logic [9:0]  meas_h_total;
  logic [9:0]  meas_v_total;

  int n_checks;
  int n_fail;
  int tx_h, tx_v;
  int prev_h, prev_v, out_h, out_v;
  logic [15:0] prev_rgb, out_rgb;
  int short_v, drop_v, cur_frame_len;
  int vcount, data_err, last_x, last_y;

  vga_sync_rx #(
    .H_ACT0(HA0), .H_VALID(HV), .H_TOTAL(HT),
    .V_ACT0(VA0), .V_VALID(VV), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .vga_clk(vga_clk),
    .sys_rst_n(sys_rst_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .rgb_in(rgb_in),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_data(pix_data),
    .frame_start(frame_start),
    .locked(locked),
    .lock_lost(lock_lost),
    .meas_h_total(meas_h_total),
    .meas_v_total(meas_v_total)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [15:0] pat(input int h, input int v);
    return 16'hA000 | 16'(v << 6) | 16'(h);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One pixel clock: drive the transmitter sample, then audit the outputs, which
  // belong to the sample driven one call earlier.
  task automatic applyStimulus();
    int line_len;
    logic act;
    line_len = (tx_v == short_v) ? HT - 1 : HT;
    act = (tx_h >= HA0) && (tx_h < HA0 + HV) && (tx_v >= VA0) && (tx_v < VA0 + VV);
    hsync_in = (tx_v != drop_v) && (tx_h < HS);
    vsync_in = (tx_v < VS);
    rgb_in   = act ? pat(tx_h, tx_v) : 16'h0000;
    @(posedge vga_clk);
    #1;
    out_h   = prev_h;
    out_v   = prev_v;
    out_rgb = prev_rgb;
    if (pix_valid) begin
      vcount++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      if (int'(pix_x) != out_h - HA0 || int'(pix_y) != out_v - VA0 || pix_data != out_rgb)
        data_err++;
    end else if (pix_x != 10'h3ff || pix_y != 10'h3ff || pix_data != 16'h0000) begin
      data_err++;
    end
    prev_h   = tx_h;
    prev_v   = tx_v;
    prev_rgb = rgb_in;
    tx_h++;
    if (tx_h >= line_len) begin
      tx_h = 0;
      tx_v++;
      if (tx_v >= cur_frame_len) begin
        tx_v = 0;
        cur_frame_len = VT;
      end
    end
  endtask

  task automatic runToSample(input int h, input int v, input string tag);
    logic reached;
    reached = 1'b0;
    for (int i = 0; i < 2 * HT * VT + 10; i++) begin
      applyStimulus();
      if (out_h == h && out_v == v) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) checkOutput($sformatf("%s_reach", tag), {31'd0, reached}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput($sformatf("%s_pix_valid", tag), {31'd0, pix_valid}, 32'd0);
    checkOutput($sformatf("%s_pix_x", tag), {22'd0, pix_x}, 32'h3ff);
    checkOutput($sformatf("%s_pix_y", tag), {22'd0, pix_y}, 32'h3ff);
    checkOutput($sformatf("%s_pix_data", tag), {16'd0, pix_data}, 32'h0);
    checkOutput($sformatf("%s_frame_start", tag), {31'd0, frame_start}, 32'd0);
    checkOutput($sformatf("%s_locked", tag), {31'd0, locked}, 32'd0);
    checkOutput($sformatf("%s_lock_lost", tag), {31'd0, lock_lost}, 32'd0);
    checkOutput($sformatf("%s_meas_h", tag), {22'd0, meas_h_total}, 32'd0);
    checkOutput($sformatf("%s_meas_v", tag), {22'd0, meas_v_total}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    tx_h = 8; tx_v = 6;
    prev_h = -1; prev_v = -1; prev_rgb = 16'h0000;
    out_h = -1; out_v = -1; out_rgb = 16'h0000;
    short_v = -1; drop_v = -1; cur_frame_len = VT;
    vcount = 0; data_err = 0; last_x = -1; last_y = -1;
    sys_rst_n = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 16'h0000;

    repeat (3) applyStimulus();
    checkResetOutputs("rst");
    sys_rst_n = 1'b1;

    // Acquire lock from mid-frame: lock appears at the third vsync rise.
    runToSample(0, 0, "f1");
    checkOutput("f1_locked", {31'd0, locked}, 32'd0);
    checkOutput("f1_frame_start", {31'd0, frame_start}, 32'd1);
    applyStimulus();
    checkOutput("f1_frame_start_pulse", {31'd0, frame_start}, 32'd0);
    runToSample(0, 0, "f2");
    checkOutput("f2_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f3");
    checkOutput("f3_locked", {31'd0, locked}, 32'd1);
    checkOutput("f3_meas_v", {22'd0, meas_v_total}, VT);
    runToSample(HA0, VA0, "first_pix");
    checkOutput("first_pix_valid", {31'd0, pix_valid}, 32'd1);
    checkOutput("first_pix_x", {22'd0, pix_x}, 32'd0);
    checkOutput("first_pix_y", {22'd0, pix_y}, 32'd0);
    checkOutput("first_pix_data", {16'd0, pix_data}, {16'd0, pat(HA0, VA0)});

    // One full locked frame.
    runToSample(0, 0, "f4");
    vcount = 0;
    runToSample(0, 0, "f5");
    checkOutput("frame_pix_count", vcount, HV * VV);
    checkOutput("frame_last_x", last_x, HV - 1);
    checkOutput("frame_last_y", last_y, VV - 1);
    checkOutput("frame_meas_h", {22'd0, meas_h_total}, HT);
    checkOutput("frame_meas_v", {22'd0, meas_v_total}, VT);
    checkOutput("frame_locked", {31'd0, locked}, 32'd1);

    // A single short line while locked.
    short_v = 4;
    runToSample(0, 5, "short_line");
    checkOutput("short_lock_lost", {31'd0, lock_lost}, 32'd1);
    checkOutput("short_locked", {31'd0, locked}, 32'd0);
    checkOutput("short_meas_h", {22'd0, meas_h_total}, HT - 1);
    short_v = -1;
    applyStimulus();
    checkOutput("short_lock_lost_pulse", {31'd0, lock_lost}, 32'd0);
    runToSample(HA0, 5, "short_blank");
    checkOutput("short_pix_valid", {31'd0, pix_valid}, 32'd0);
    checkOutput("short_pix_x", {22'd0, pix_x}, 32'h3ff);
    checkOutput("short_pix_y", {22'd0, pix_y}, 32'h3ff);
    runToSample(0, 0, "f6");
    checkOutput("f6_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f7");
    checkOutput("f7_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f8");
    checkOutput("f8_relocked", {31'd0, locked}, 32'd1);

    // Missing hsync on one line while locked.
    drop_v = 4;
    runToSample(0, 4, "drop_line");
    checkOutput("drop_lock_lost", {31'd0, lock_lost}, 32'd1);
    checkOutput("drop_locked", {31'd0, locked}, 32'd0);
    checkOutput("drop_meas_h_hold", {22'd0, meas_h_total}, HT);
    runToSample(0, 5, "drop_next");
    checkOutput("drop_meas_h_long", {22'd0, meas_h_total}, 2 * HT);
    drop_v = -1;

    // A short frame while checking resets the clean-frame count.
    runToSample(0, 0, "f9");
    checkOutput("f9_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f10");
    checkOutput("f10_locked", {31'd0, locked}, 32'd0);
    cur_frame_len = VT - 1;
    runToSample(0, 0, "f11");
    checkOutput("f11_meas_v", {22'd0, meas_v_total}, VT - 1);
    checkOutput("f11_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f12");
    checkOutput("f12_locked", {31'd0, locked}, 32'd0);
    runToSample(0, 0, "f13");
    checkOutput("f13_locked", {31'd0, locked}, 32'd1);

    // Reset in the middle of a locked frame.
    runToSample(10, 5, "mid_frame");
    checkOutput("mid_pix_valid", {31'd0, pix_valid}, 32'd1);
    sys_rst_n = 1'b0;
    applyStimulus();
    checkResetOutputs("midrst");
    applyStimulus();
    sys_rst_n = 1'b1;
    runToSample(0, 0, "f14");
    checkOutput("f14_locked", {31'd0, locked}, 32'd0);
    checkOutput("f14_frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("f14_meas_v_skip", {22'd0, meas_v_total}, 32'd0);
    checkOutput("f14_meas_h", {22'd0, meas_h_total}, HT);
    runToSample(0, 0, "f15");
    checkOutput("f15_locked", {31'd0, locked}, 32'd0);
    checkOutput("f15_meas_v", {22'd0, meas_v_total}, VT);
    runToSample(0, 0, "f16");
    checkOutput("f16_locked", {31'd0, locked}, 32'd1);

    checkOutput("pixel_stream_errors", data_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
